// File: rtl/hyperfabric_pkg.sv
// Shared widths, lane count and block-mover state encoding for the
// Gremlin-side fabric blocks.
package hyperfabric_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int CNT_W_DEF  = 6;
    localparam int DATA_W_DEF = 16;
    localparam int LANES      = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } mover_state_t;

endpackage

// File: rtl/block_mover_skid.sv
// Two-entry holding pair (output register + skid) absorbing the one-cycle
// buffer read latency so a stalled stream never loses an in-flight word.
module block_mover_skid
    import hyperfabric_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              out_ready,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        credits
);

    logic              vld_p1;
    logic              hold_vld_p2;
    logic              skid_vld_p2;
    logic [DATA_W-1:0] hold_data_p2;
    logic [DATA_W-1:0] skid_data_p2;
    logic              hold_vld_nxt;
    logic              skid_vld_nxt;
    logic [DATA_W-1:0] hold_data_nxt;
    logic [DATA_W-1:0] skid_data_nxt;
    logic              pop;

    // An arriving word is presented straight from the RAM when nothing is held.
    assign out_vld  = hold_vld_p2 | vld_p1;
    assign out_data = hold_vld_p2 ? hold_data_p2 : rd_data;
    assign credits  = 2'(hold_vld_p2) + 2'(skid_vld_p2) + 2'(vld_p1);
    assign pop      = out_vld & out_ready;

    always_comb begin
        hold_vld_nxt  = hold_vld_p2;
        hold_data_nxt = hold_data_p2;
        skid_vld_nxt  = skid_vld_p2;
        skid_data_nxt = skid_data_p2;
        if (!hold_vld_p2) begin
            hold_vld_nxt  = vld_p1 & ~pop;
            hold_data_nxt = rd_data;
        end else if (!skid_vld_p2) begin
            if (pop) begin
                hold_vld_nxt  = vld_p1;
                hold_data_nxt = rd_data;
            end else begin
                skid_vld_nxt  = vld_p1;
                skid_data_nxt = rd_data;
            end
        end else if (pop) begin
            hold_data_nxt = skid_data_p2;
            skid_vld_nxt  = 1'b0;
        end
    end

    // Stage p1: read issued last cycle, data on rd_data now.
    always_ff @(posedge CLK) begin
        if (!RST || flush) begin
            vld_p1      <= 1'b0;
            hold_vld_p2 <= 1'b0;
            skid_vld_p2 <= 1'b0;
        end else begin
            vld_p1      <= rd_en;
            hold_vld_p2 <= hold_vld_nxt;
            skid_vld_p2 <= skid_vld_nxt;
        end
    end

    // Stage p2: captured words, no reset needed behind the valid bits.
    always_ff @(posedge CLK) begin
        hold_data_p2 <= hold_data_nxt;
        skid_data_p2 <= skid_data_nxt;
    end

endmodule

// File: rtl/block_mover.sv
// Streams a Gremlin-issued block of buffer words to one device lane and
// reports progress, completion IRQ toggle and termination cause.
module block_mover
    import hyperfabric_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ISSUE,
    input  logic [ADDR_W-1:0] START,
    input  logic [CNT_W-1:0]  COUNT_REQ,
    input  logic [1:0]        SECTION,
    input  logic              ABORT,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic              MEM_RE,
    input  logic [DATA_W-1:0] MEM_RDATA,
    output logic [DATA_W-1:0] DEV_DATA,
    output logic [LANES-1:0]  DEV_VALID,
    input  logic [LANES-1:0]  DEV_READY,
    input  logic [LANES-1:0]  DEV_ERR,
    output logic              WORKING,
    output logic [CNT_W-1:0]  COUNT_SENT,
    output logic              IRQ,
    output logic              ABRUPT_STOP,
    output logic              FRDRAM_DEVERR
);

    mover_state_t      state, state_nxt;
    logic              issue_q;
    logic [ADDR_W-1:0] next_addr;
    logic [CNT_W:0]    reads_left;
    logic [CNT_W:0]    words_left;
    logic [CNT_W:0]    req_words;
    logic [1:0]        section;
    logic [LANES-1:0]  lane_sel;
    logic              start, kill, accept, done, rd_en;
    logic              sel_ready, sel_err;
    logic              out_vld;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        credits;

    assign req_words = (COUNT_REQ == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, COUNT_REQ};
    assign lane_sel  = LANES'(1) << section;
    assign sel_ready = DEV_READY[section];
    assign sel_err   = DEV_ERR[section];

    // ABORT held while idle swallows the command edge instead of deferring it.
    assign start  = (state == IDLE) && (ISSUE != issue_q) && !ABORT;
    assign kill   = (state == STREAM) && (ABORT || sel_err);
    assign accept = (state == STREAM) && out_vld && sel_ready;
    assign done   = accept && (words_left == (CNT_W+1)'(1));
    assign rd_en  = (state == STREAM) && (credits < 2'd2) && (reads_left != '0);

    assign MEM_RE    = rd_en;
    assign MEM_ADDR  = next_addr;
    assign WORKING   = (state == STREAM);
    assign DEV_VALID = (state == STREAM && out_vld) ? lane_sel : '0;
    assign DEV_DATA  = (DEV_VALID != '0) ? out_data : '0;

    always_ff @(posedge CLK) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = STREAM;
            STREAM:  if (kill || done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            issue_q       <= 1'b0;
            next_addr     <= '0;
            reads_left    <= '0;
            words_left    <= '0;
            section       <= '0;
            COUNT_SENT    <= '0;
            IRQ           <= 1'b0;
            ABRUPT_STOP   <= 1'b0;
            FRDRAM_DEVERR <= 1'b0;
        end else begin
            issue_q <= ISSUE;
            if (start) begin
                next_addr     <= START;
                reads_left    <= req_words;
                words_left    <= req_words;
                section       <= SECTION;
                COUNT_SENT    <= '0;
                ABRUPT_STOP   <= 1'b0;
                FRDRAM_DEVERR <= 1'b0;
            end else if (state == STREAM) begin
                if (rd_en) begin
                    next_addr  <= next_addr + ADDR_W'(1);
                    reads_left <= reads_left - (CNT_W+1)'(1);
                end
                if (accept) begin
                    COUNT_SENT <= COUNT_SENT + CNT_W'(1);
                    words_left <= words_left - (CNT_W+1)'(1);
                end
                if (kill) begin
                    ABRUPT_STOP   <= ABORT;
                    FRDRAM_DEVERR <= sel_err;
                end
                if (kill || done) IRQ <= ~IRQ;
            end
        end
    end

    block_mover_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .CLK       (CLK),
        .RST       (RST),
        .flush     (kill),
        .rd_en     (rd_en),
        .rd_data   (MEM_RDATA),
        .out_ready (sel_ready),
        .out_vld   (out_vld),
        .out_data  (out_data),
        .credits   (credits)
    );

endmodule

// File: tb/tb_block_mover.sv
// Randomized bench for block_mover: buffer RAM model plus a word-queue
// reference of what each command must deliver.
module tb_block_mover;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ISSUE;
    logic [11:0] START;
    logic [5:0]  COUNT_REQ;
    logic [1:0]  SECTION;
    logic        ABORT;
    logic [11:0] MEM_ADDR;
    logic        MEM_RE;
    logic [15:0] ram_q;
    logic [15:0] DEV_DATA;
    logic [3:0]  DEV_VALID;
    logic [3:0]  DEV_READY;
    logic [3:0]  DEV_ERR;
    logic        WORKING;
    logic [5:0]  COUNT_SENT;
    logic        IRQ;
    logic        ABRUPT_STOP;
    logic        FRDRAM_DEVERR;

    block_mover dut (
        .CLK           (CLK),
        .RST           (RST),
        .ISSUE         (ISSUE),
        .START         (START),
        .COUNT_REQ     (COUNT_REQ),
        .SECTION       (SECTION),
        .ABORT         (ABORT),
        .MEM_ADDR      (MEM_ADDR),
        .MEM_RE        (MEM_RE),
        .MEM_RDATA     (ram_q),
        .DEV_DATA      (DEV_DATA),
        .DEV_VALID     (DEV_VALID),
        .DEV_READY     (DEV_READY),
        .DEV_ERR       (DEV_ERR),
        .WORKING       (WORKING),
        .COUNT_SENT    (COUNT_SENT),
        .IRQ           (IRQ),
        .ABRUPT_STOP   (ABRUPT_STOP),
        .FRDRAM_DEVERR (FRDRAM_DEVERR)
    );

    always #5 CLK = ~CLK;

    // Section buffer: one-cycle read latency, request sampled mid-cycle.
    logic [15:0] mem [4096];
    logic        re_s;
    logic [11:0] addr_s;
    always @(negedge CLK) begin
        re_s   <= MEM_RE;
        addr_s <= MEM_ADDR;
    end
    always @(posedge CLK) if (re_s) ram_q <= mem[addr_s];

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Reference state for the current command
    logic [15:0] exp_q[$];
    int          m_sec = 0;
    int          m_n = 0;
    logic [11:0] m_rd_addr = '0;
    int          m_reads = 0, accepts = 0;
    int          t0 = 0, first_re = -1, first_vld = -1, work_fall = -1;
    int          toggles = 0, irq0 = 0;
    int          rdy_mode = 0;
    logic        irq_prev = 1'b0, work_prev = 1'b0;
    logic        prev_stall = 1'b0, prev_kill = 1'b0;
    logic [15:0] prev_data = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic observe();
        logic [3:0] lane;
        lane = 4'b0001 << m_sec;
        check("lane_onehot", {28'd0, DEV_VALID & ~lane}, 0);
        if (MEM_RE) begin
            check("rd_addr", {20'd0, MEM_ADDR}, {20'd0, m_rd_addr});
            if (first_re < 0) first_re = cyc;
            m_rd_addr = m_rd_addr + 12'd1;
            m_reads++;
        end
        if (prev_stall && !prev_kill) begin
            check("stall_vld", {31'd0, |(DEV_VALID & lane)}, 1);
            check("stall_data", {16'd0, DEV_DATA}, {16'd0, prev_data});
        end
        if (|(DEV_VALID & lane)) begin
            if (first_vld < 0) first_vld = cyc;
            if (|(DEV_READY & lane)) begin
                accepts++;
                if (exp_q.size() == 0) check("extra_word", accepts, m_n);
                else check("word", {16'd0, DEV_DATA}, {16'd0, exp_q.pop_front()});
            end
        end
        prev_stall = |(DEV_VALID & lane) && !(|(DEV_READY & lane));
        prev_kill  = ABORT || |(DEV_ERR & lane) || !RST;
        prev_data  = DEV_DATA;
        if (IRQ != irq_prev) toggles++;
        if (work_prev && !WORKING && work_fall < 0) work_fall = cyc;
        irq_prev  = IRQ;
        work_prev = WORKING;
    endtask

    task automatic cycle();
        @(negedge CLK);
        observe();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic start_cmd(input int s, input int c, input int sec);
        logic [11:0] a;
        START     = 12'(s);
        COUNT_REQ = 6'(c);
        SECTION   = 2'(sec);
        ISSUE     = ~ISSUE;
        m_n = (c == 0) ? 64 : c;
        exp_q.delete();
        for (int i = 0; i < m_n; i++) begin
            a = 12'(s + i);
            exp_q.push_back(mem[a]);
        end
        m_sec = sec;
        m_rd_addr = 12'(s);
        m_reads = 0;
        accepts = 0;
        t0 = cyc;
        first_re = -1;
        first_vld = -1;
        work_fall = -1;
        irq0 = toggles;
    endtask

    task automatic drive_ready();
        logic [3:0] lane;
        logic [4:0] pat;
        int k;
        lane = 4'b0001 << m_sec;
        pat = 5'b11001;
        k = cyc - t0 - 2;
        if (rdy_mode == 1) begin
            DEV_READY = ((k >= 0 && k < 5) ? pat[k] : 1'b1) ? lane : 4'b0;
        end else if (rdy_mode == 2) begin
            DEV_READY = (4'($urandom) & ~lane) | (($urandom_range(0, 3) != 0) ? lane : 4'b0);
            DEV_ERR   = 4'($urandom) & ~lane;
        end
    endtask

    task automatic wait_done(input int limit);
        int k;
        k = 0;
        while (work_fall < 0 && k < limit) begin
            drive_ready();
            cycle();
            k++;
        end
        if (work_fall < 0) check("timeout_working", {31'd0, WORKING}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
        RST = 1'b0; ISSUE = 1'b0; START = '0; COUNT_REQ = '0; SECTION = '0;
        ABORT = 1'b0; DEV_READY = '0; DEV_ERR = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_working", {31'd0, WORKING}, 0);
        check("rst_flags", {28'd0, IRQ, ABRUPT_STOP, FRDRAM_DEVERR, MEM_RE}, 0);
        check("rst_count", {26'd0, COUNT_SENT}, 0);
        check("rst_valid_data", {12'd0, DEV_VALID, DEV_DATA}, 0);
        check("rst_addr", {20'd0, MEM_ADDR}, 0);
        RST = 1'b1;
        cycle();

        // Basic 4-word transfer on lane 1 with ready held high
        rdy_mode = 0;
        DEV_READY = 4'b0010;
        start_cmd(12'h010, 4, 1);
        cycle();
        check("t1_working", {31'd0, WORKING}, 1);
        check("t1_count_clr", {26'd0, COUNT_SENT}, 0);
        wait_done(30);
        check("t1_first_read", first_re - t0, 1);
        check("t1_first_valid", first_vld - t0, 2);
        check("t1_work_fall", work_fall - t0, 6);
        check("t1_reads", m_reads, 4);
        check("t1_accepts", accepts, 4);
        check("t1_count", {26'd0, COUNT_SENT}, 4);
        check("t1_irq", toggles - irq0, 1);
        check("t1_flags", {30'd0, ABRUPT_STOP, FRDRAM_DEVERR}, 0);

        // Address wrap with ready stalls
        rdy_mode = 1;
        start_cmd(12'hFFE, 3, 3);
        cycle();
        wait_done(30);
        check("t2_reads", m_reads, 3);
        check("t2_wrap_addr", {20'd0, m_rd_addr}, 12'h001);
        check("t2_accepts", accepts, 3);
        check("t2_count", {26'd0, COUNT_SENT}, 3);
        check("t2_left", exp_q.size(), 0);
        check("t2_irq", toggles - irq0, 1);

        // COUNT_REQ=0 moves 64 words
        rdy_mode = 2;
        start_cmd(int'($urandom_range(0, 4095)), 0, int'($urandom_range(0, 3)));
        cycle();
        wait_done(400);
        DEV_ERR = '0;
        check("t3_accepts", accepts, 64);
        check("t3_reads", m_reads, 64);
        check("t3_count", {26'd0, COUNT_SENT}, 0);
        check("t3_left", exp_q.size(), 0);
        check("t3_irq", toggles - irq0, 1);

        // ABORT after 5 accepts of 20
        rdy_mode = 0;
        DEV_READY = 4'b0001;
        start_cmd(12'h123, 20, 0);
        while (cyc < t0 + 7) cycle();
        check("t4_pre_accepts", accepts, 5);
        ABORT = 1'b1;
        DEV_READY = 4'b0000;
        cycle();
        check("t4_valid", {28'd0, DEV_VALID}, 0);
        check("t4_re", {31'd0, MEM_RE}, 0);
        check("t4_working", {31'd0, WORKING}, 0);
        check("t4_flags", {30'd0, ABRUPT_STOP, FRDRAM_DEVERR}, 2'b10);
        check("t4_count", {26'd0, COUNT_SENT}, 5);
        ABORT = 1'b0;
        cycle();
        check("t4_irq", toggles - irq0, 1);
        check("t4_accepts", accepts, 5);

        // DEV_ERR on lane 2 after 2 accepts, extra ISSUE toggle while busy
        DEV_READY = 4'b0100;
        start_cmd(12'h200, 10, 2);
        cycle();
        ISSUE = ~ISSUE;
        cycle();
        cycle();
        cycle();
        DEV_READY = 4'b0000;
        DEV_ERR = 4'b0100;
        cycle();
        check("t5_working", {31'd0, WORKING}, 0);
        check("t5_flags", {30'd0, ABRUPT_STOP, FRDRAM_DEVERR}, 2'b01);
        check("t5_count", {26'd0, COUNT_SENT}, 2);
        check("t5_valid", {28'd0, DEV_VALID}, 0);
        DEV_ERR = '0;
        repeat (4) cycle();
        check("t5_stay_idle", {30'd0, WORKING, MEM_RE}, 0);
        check("t5_accepts", accepts, 2);
        check("t5_irq", toggles - irq0, 1);

        // Reset in the middle of a transfer, then a clean command
        DEV_READY = 4'b0010;
        start_cmd(12'h7F0, 30, 1);
        repeat (5) cycle();
        RST = 1'b0;
        ISSUE = 1'b0;
        cycle();
        check("t6_rst_ctrl", {28'd0, WORKING, IRQ, MEM_RE, ABRUPT_STOP}, 0);
        check("t6_rst_out", {6'd0, COUNT_SENT, DEV_VALID, DEV_DATA}, 0);
        check("t6_rst_addr", {20'd0, MEM_ADDR}, 0);
        RST = 1'b1;
        cycle();
        check("t6_no_cmd", {31'd0, WORKING}, 0);
        start_cmd(12'h055, 7, 1);
        cycle();
        wait_done(40);
        check("t6_accepts", accepts, 7);
        check("t6_count", {26'd0, COUNT_SENT}, 7);
        check("t6_left", exp_q.size(), 0);
        check("t6_irq", toggles - irq0, 1);

        // Random transfers, random lanes, random ready and foreign-lane errors
        rdy_mode = 2;
        for (int t = 0; t < 8; t++) begin
            int c;
            c = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 25));
            start_cmd(int'($urandom_range(0, 4095)), c, int'($urandom_range(0, 3)));
            cycle();
            wait_done(400);
            DEV_ERR = '0;
            check("rnd_accepts", accepts, m_n);
            check("rnd_reads", m_reads, m_n);
            check("rnd_count", {26'd0, COUNT_SENT}, 32'(m_n % 64));
            check("rnd_left", exp_q.size(), 0);
            check("rnd_irq", toggles - irq0, 1);
            check("rnd_flags", {30'd0, ABRUPT_STOP, FRDRAM_DEVERR}, 0);
            repeat (int'($urandom_range(1, 3))) cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
